// File: rtl/adxl357_pkg.sv
// Shared definitions for the ADXL357 bring-up sequencer: controller op-mode
// codes, device register map, the fixed initialisation table and FSM types.
package adxl357_pkg;

   // I2C controller op_mode codes (ctrl[3:1])
   localparam logic [2:0] OP_CPU_RREG = 3'd0;
   localparam logic [2:0] OP_CPU_WREG = 3'd1;
   localparam logic [2:0] OP_HW       = 3'd4;

   // ADXL357 register addresses
   localparam logic [7:0] REG_DEVID     = 8'h00;
   localparam logic [7:0] REG_FILTER    = 8'h28;
   localparam logic [7:0] REG_RANGE     = 8'h2C;
   localparam logic [7:0] REG_POWER_CTL = 8'h2D;
   localparam logic [7:0] REG_RESET     = 8'h2F;

   localparam logic [7:0] DEVID_VALUE = 8'hAD;
   localparam logic [7:0] RESET_CODE  = 8'h52;

   // Table positions with special handling
   localparam logic [2:0] DEVID_STEP = 3'd0;
   localparam logic [2:0] RESET_STEP = 3'd1;
   localparam logic [2:0] LAST_STEP  = 3'd4;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
      logic [2:0] op_mode;
   } init_entry_t;

   // Bring-up table: DEVID check, soft reset, range, filter, measurement on
   localparam init_entry_t INIT_TABLE [0:4] = '{
      '{REG_DEVID,     8'h00,      OP_CPU_RREG},
      '{REG_RESET,     RESET_CODE, OP_CPU_WREG},
      '{REG_RANGE,     8'h81,      OP_CPU_WREG},
      '{REG_FILTER,    8'h00,      OP_CPU_WREG},
      '{REG_POWER_CTL, 8'h00,      OP_CPU_WREG}
   };

   typedef enum logic [1:0] {
      ERR_NONE    = 2'd0,
      ERR_DEVID   = 2'd1,
      ERR_NACK    = 2'd2,
      ERR_TIMEOUT = 2'd3
   } err_code_e;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_LOAD      = 4'd1,
      ST_REQ       = 4'd2,
      ST_WAIT_DONE = 4'd3,
      ST_CHECK     = 4'd4,
      ST_RST_WAIT  = 4'd5,
      ST_RUN       = 4'd6,
      ST_STOPPING  = 4'd7,
      ST_ERROR     = 4'd8
   } state_e;

   // Table lookup that stays well defined for out-of-range step values
   function automatic init_entry_t init_entry(input logic [2:0] step);
      if (step <= LAST_STEP) begin
         return INIT_TABLE[step];
      end else begin
         return INIT_TABLE[0];
      end
   endfunction

endpackage

// File: rtl/adxl357_init_sequencer.sv
// ADXL357 bring-up sequencer: walks the init table through the I2C
// controller (with retry/timeout recovery) and then hands the controller
// over to hardware DRDY streaming until stopped.
module adxl357_init_sequencer
   import adxl357_pkg::*;
#(
   parameter logic [2:0]  CLK_RATE     = 3'd6,
   parameter int unsigned TIMEOUT_CYC  = 2_000_000,
   parameter int unsigned RST_WAIT_CYC = 500_000,
   parameter int unsigned MAX_RETRY    = 2
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_stop,
   input  logic [31:0] i_i2c_status,
   input  logic [7:0]  i_rd_data,
   output logic [31:0] o_ctrl,
   output logic [7:0]  o_reg_addr,
   output logic [7:0]  o_w_data,
   output logic        o_busy,
   output logic        o_running,
   output logic        o_err,
   output logic [1:0]  o_err_code,
   output logic [2:0]  o_step
);

   state_e      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [3:0]  retry_q, retry_d;
   logic [31:0] timer_q, timer_d;
   logic        finish_seen_q, finish_seen_d;
   logic        timed_out_q, timed_out_d;
   logic        en_q, en_d;
   logic [2:0]  op_mode_q, op_mode_d;
   logic [7:0]  reg_addr_q, reg_addr_d;
   logic [7:0]  w_data_q, w_data_d;
   logic        busy_q, busy_d;
   logic        running_q, running_d;
   logic        err_q, err_d;
   err_code_e   err_code_q, err_code_d;
   logic        sm_enable_q, sm_enable_d;
   logic        finish_q, finish_d;

   logic        go_load_s;
   logic        fail_s;
   err_code_e   fail_code_s;
   init_entry_t entry_s;
   logic        unused_status_s;

   // Only finish and sm_enable are consumed from the status word
   assign unused_status_s = ^{i_i2c_status[31:11], i_i2c_status[9:2], i_i2c_status[0]};

   // Next-state, datapath and output computation for the sequencer
   always_comb begin
      state_d       = state_q;
      step_d        = step_q;
      retry_d       = retry_q;
      timer_d       = timer_q;
      finish_seen_d = finish_seen_q;
      timed_out_d   = timed_out_q;
      en_d          = en_q;
      op_mode_d     = op_mode_q;
      err_d         = err_q;
      err_code_d    = err_code_q;
      sm_enable_d   = i_i2c_status[10];
      finish_d      = i_i2c_status[1];
      go_load_s     = 1'b0;
      fail_s        = 1'b0;
      fail_code_s   = ERR_NONE;

      case (state_q)
         ST_IDLE, ST_ERROR: begin
            if (i_start) begin
               step_d     = DEVID_STEP;
               retry_d    = 4'd0;
               err_d      = 1'b0;
               err_code_d = ERR_NONE;
               go_load_s  = 1'b1;
            end else begin
               en_d = 1'b0;
            end
         end
         ST_LOAD: begin
            finish_seen_d = 1'b0;
            timed_out_d   = 1'b0;
            timer_d       = 32'(TIMEOUT_CYC);
            en_d          = 1'b1;
            state_d       = ST_REQ;
         end
         ST_REQ: begin
            if (timer_q == 32'd0) begin
               // Controller never picked the request up: abandon it
               en_d        = 1'b0;
               timed_out_d = 1'b1;
               timer_d     = 32'(TIMEOUT_CYC);
               state_d     = ST_WAIT_DONE;
            end else if (sm_enable_q) begin
               en_d    = 1'b0;
               timer_d = timer_q - 32'd1;
               state_d = ST_WAIT_DONE;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_WAIT_DONE: begin
            finish_seen_d = finish_seen_q | finish_q;
            if (!sm_enable_q) begin
               state_d = ST_CHECK;
            end else if (timer_q == 32'd0) begin
               if (timed_out_q) begin
                  // Second budget expired with the controller still busy
                  state_d    = ST_ERROR;
                  err_d      = 1'b1;
                  err_code_d = ERR_TIMEOUT;
               end else begin
                  timed_out_d = 1'b1;
                  timer_d     = 32'(TIMEOUT_CYC);
               end
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_CHECK: begin
            if (timed_out_q) begin
               fail_s      = 1'b1;
               fail_code_s = ERR_TIMEOUT;
            end else if (step_q == DEVID_STEP) begin
               if (i_rd_data != DEVID_VALUE) begin
                  state_d    = ST_ERROR;
                  err_d      = 1'b1;
                  err_code_d = ERR_DEVID;
               end else begin
                  step_d    = step_q + 3'd1;
                  retry_d   = 4'd0;
                  go_load_s = 1'b1;
               end
            end else if (!finish_seen_q) begin
               fail_s      = 1'b1;
               fail_code_s = ERR_NACK;
            end else if (step_q == RESET_STEP) begin
               timer_d = 32'(RST_WAIT_CYC - 32'd1);
               state_d = ST_RST_WAIT;
            end else if (step_q == LAST_STEP) begin
               op_mode_d = OP_HW;
               en_d      = 1'b0;
               state_d   = ST_RUN;
            end else begin
               step_d    = step_q + 3'd1;
               retry_d   = 4'd0;
               go_load_s = 1'b1;
            end

            if (fail_s) begin
               if (retry_q >= 4'(MAX_RETRY)) begin
                  state_d    = ST_ERROR;
                  err_d      = 1'b1;
                  err_code_d = fail_code_s;
               end else begin
                  retry_d   = retry_q + 4'd1;
                  go_load_s = 1'b1;
               end
            end else begin
               fail_code_s = ERR_NONE;
            end
         end
         ST_RST_WAIT: begin
            if (timer_q == 32'd0) begin
               step_d    = step_q + 3'd1;
               retry_d   = 4'd0;
               go_load_s = 1'b1;
            end else begin
               timer_d = timer_q - 32'd1;
            end
         end
         ST_RUN: begin
            if (i_stop) begin
               op_mode_d = OP_CPU_WREG;
               state_d   = ST_STOPPING;
            end else begin
               op_mode_d = OP_HW;
            end
         end
         ST_STOPPING: begin
            if (!sm_enable_q) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_STOPPING;
            end
         end
         default: begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
         end
      endcase

      // Entering LOAD presents the selected table entry to the controller
      entry_s    = init_entry(step_d);
      state_d    = go_load_s ? ST_LOAD : state_d;
      en_d       = go_load_s ? 1'b0 : en_d;
      op_mode_d  = go_load_s ? entry_s.op_mode : op_mode_d;
      reg_addr_d = go_load_s ? entry_s.addr : reg_addr_q;
      w_data_d   = go_load_s ? entry_s.data : w_data_q;

      busy_d    = !((state_d == ST_IDLE) || (state_d == ST_RUN) || (state_d == ST_ERROR));
      running_d = (state_d == ST_RUN);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q       <= ST_IDLE;
         step_q        <= 3'd0;
         retry_q       <= 4'd0;
         timer_q       <= 32'd0;
         finish_seen_q <= 1'b0;
         timed_out_q   <= 1'b0;
         en_q          <= 1'b0;
         op_mode_q     <= OP_CPU_WREG;
         reg_addr_q    <= 8'd0;
         w_data_q      <= 8'd0;
         busy_q        <= 1'b0;
         running_q     <= 1'b0;
         err_q         <= 1'b0;
         err_code_q    <= ERR_NONE;
         sm_enable_q   <= 1'b0;
         finish_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         step_q        <= step_d;
         retry_q       <= retry_d;
         timer_q       <= timer_d;
         finish_seen_q <= finish_seen_d;
         timed_out_q   <= timed_out_d;
         en_q          <= en_d;
         op_mode_q     <= op_mode_d;
         reg_addr_q    <= reg_addr_d;
         w_data_q      <= w_data_d;
         busy_q        <= busy_d;
         running_q     <= running_d;
         err_q         <= err_d;
         err_code_q    <= err_code_d;
         sm_enable_q   <= sm_enable_d;
         finish_q      <= finish_d;
      end
   end

   assign o_ctrl     = {25'd0, CLK_RATE, op_mode_q, en_q};
   assign o_reg_addr = reg_addr_q;
   assign o_w_data   = w_data_q;
   assign o_busy     = busy_q;
   assign o_running  = running_q;
   assign o_err      = err_q;
   assign o_err_code = err_code_q;
   assign o_step     = step_q;

endmodule

// File: tb/tb_adxl357_init_sequencer.sv
// Self-checking bench for adxl357_init_sequencer: a behavioural I2C
// controller answers the sequencer, a scenario-level model predicts the
// transaction list and final outcome, and a per-cycle monitor checks
// output rules on every cycle.
module tb_adxl357_init_sequencer;

   localparam int         T    = 200;
   localparam int         R    = 50;
   localparam int         MR   = 2;
   localparam logic [2:0] RATE = 3'd6;
   localparam int         NONE = 99;

   logic        clk = 1'b0;
   logic        rst, start, stop;
   logic [31:0] status;
   logic [7:0]  rd_data;
   logic [31:0] o_ctrl;
   logic [7:0]  o_reg_addr, o_w_data;
   logic        o_busy, o_running, o_err;
   logic [1:0]  o_err_code;
   logic [2:0]  o_step;

   always #5 clk = ~clk;

   adxl357_init_sequencer #(
      .CLK_RATE(RATE), .TIMEOUT_CYC(T), .RST_WAIT_CYC(R), .MAX_RETRY(MR)
   ) dut (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
      .i_i2c_status(status), .i_rd_data(rd_data),
      .o_ctrl(o_ctrl), .o_reg_addr(o_reg_addr), .o_w_data(o_w_data),
      .o_busy(o_busy), .o_running(o_running), .o_err(o_err),
      .o_err_code(o_err_code), .o_step(o_step)
   );

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [2:0] op;
      int         t_start;
      int         t_end;
   } txn_t;

   // Bench's own copy of the bring-up table
   logic [7:0] tbl_addr [5] = '{8'h00, 8'h2F, 8'h2C, 8'h28, 8'h2D};
   logic [7:0] tbl_data [5] = '{8'h00, 8'h52, 8'h81, 8'h00, 8'h00};
   logic [2:0] tbl_op   [5] = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1};

   txn_t       log_q[$];
   txn_t       exp_q[$];
   logic       exp_err, exp_run;
   logic [1:0] exp_code;
   logic [2:0] exp_step;

   logic [7:0] devid_cfg = 8'hAD;
   int         nack_cfg [5] = '{0, 0, 0, 0, 0};
   int         hang_step = NONE;
   bit         hang_now = 1'b0;
   bit         hw_active = 1'b0;
   bit         mon_en = 1'b0;
   int         ctl_phase = 0;
   int         cyc = 0;
   int         last_done_cyc = 0;
   int         n_checks = 0;
   int         n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (ok) n_pass++;
      else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
   endtask

   function automatic int step_of(input logic [7:0] a);
      for (int i = 0; i < 5; i++) if (tbl_addr[i] == a) return i;
      return -1;
   endfunction

   // Scenario-level prediction: attempts per step, retries, final outcome
   function automatic void build_exp(input logic [7:0] devid, input int nk [5], input int hang);
      int   s = 0;
      int   fails = 0;
      int   left [5];
      txn_t t;
      left = nk;
      exp_q.delete();
      exp_err = 1'b0; exp_code = 2'd0; exp_step = 3'd0; exp_run = 1'b0;
      while (1) begin
         t.addr = tbl_addr[s]; t.data = tbl_data[s]; t.op = tbl_op[s];
         t.t_start = 0; t.t_end = 0;
         exp_q.push_back(t);
         if (s == hang) begin
            exp_err = 1'b1; exp_code = 2'd3; exp_step = 3'(s); return;
         end
         if (s == 0) begin
            if (devid != 8'hAD) begin
               exp_err = 1'b1; exp_code = 2'd1; exp_step = 3'd0; return;
            end
         end else if (left[s] > 0) begin
            left[s]--;
            fails++;
            if (fails > MR) begin
               exp_err = 1'b1; exp_code = 2'd2; exp_step = 3'(s); return;
            end
            continue;
         end
         if (s == 4) begin
            exp_run = 1'b1; exp_step = 3'd4; return;
         end
         s++;
         fails = 0;
      end
   endfunction

   // Behavioural I2C controller: accepts a request, runs a frame, ACK/NACK/hang
   initial begin
      int   dly, left, idx;
      bit   ack, sm, fin;
      txn_t t;
      sm = 1'b0; fin = 1'b0; dly = 0; left = 0; ack = 1'b1;
      status = 32'd0; rd_data = 8'd0;
      forever begin
         @(negedge clk);
         case (ctl_phase)
            0: if (!rst && o_ctrl[0]) begin
               t.addr = o_reg_addr; t.data = o_w_data; t.op = o_ctrl[3:1];
               t.t_start = cyc; t.t_end = -1;
               log_q.push_back(t);
               idx = step_of(o_reg_addr);
               ack = 1'b1;
               if (o_ctrl[3:1] == 3'd1 && idx >= 0) begin
                  if (nack_cfg[idx] > 0) begin
                     ack = 1'b0;
                     nack_cfg[idx]--;
                  end
               end
               hang_now = (idx == hang_step);
               dly = $urandom_range(0, 2);
               ctl_phase = 1;
            end
            1: if (dly == 0) begin
               sm = 1'b1; left = $urandom_range(4, 9); ctl_phase = 2;
            end else dly--;
            2: if (!hang_now) begin
               left--;
               if (ack && left <= 2) fin = 1'b1;
               if (left <= 0) begin
                  sm = 1'b0; fin = 1'b0; ctl_phase = 0;
                  log_q[$].t_end = cyc;
               end
            end
            default: ctl_phase = 0;
         endcase
         status = 32'd0;
         status[10] = sm | hw_active;
         status[1] = fin;
         rd_data = devid_cfg;
      end
   end

   // Per-cycle output rules; act value is a mask of violated rules
   initial begin
      logic       prev_err = 1'b0;
      logic [1:0] prev_code = 2'd0;
      logic [31:0] mask;
      int         idx;
      forever begin
         @(negedge clk);
         if (mon_en && !rst) begin
            mask = 32'd0;
            if (o_ctrl[31:7] != 25'd0 || o_ctrl[6:4] != RATE) mask[0] = 1'b1;
            if (o_running && (o_ctrl[3:1] != 3'd4 || o_ctrl[0] || o_busy || o_err)) mask[1] = 1'b1;
            if (o_err && (o_busy || o_running || o_err_code == 2'd0)) mask[2] = 1'b1;
            if (prev_err && o_err && o_err_code != prev_code) mask[3] = 1'b1;
            if (o_ctrl[0]) begin
               idx = int'(o_step);
               if (idx > 4 || !o_busy) mask[4] = 1'b1;
               else if (o_reg_addr != tbl_addr[idx] || o_w_data != tbl_data[idx] ||
                        o_ctrl[3:1] != tbl_op[idx]) mask[5] = 1'b1;
            end
            chk(mask == 32'd0, "cycle_rules", mask, 32'd0);
            prev_err = o_err;
            prev_code = o_err_code;
         end
      end
   end

   task automatic go_idle();
      int n = 0;
      if (o_running) begin
         @(negedge clk); stop = 1'b1;
         @(negedge clk); stop = 1'b0;
         while (o_busy && n < 100) begin @(negedge clk); n++; end
         chk(!o_busy && !o_running, "stop_to_idle", {30'd0, o_busy, o_running}, 32'd0);
      end
      n = 0;
      while (ctl_phase != 0 && n < 200) begin @(negedge clk); n++; end
      chk(ctl_phase == 0, "controller_idle", ctl_phase, 32'd0);
   endtask

   task automatic run_scn(input string nm, input logic [7:0] devid,
                          input int n1, input int n2, input int n3, input int n4, input int hang);
      int nk [5];
      int n = 0;
      nk = '{0, n1, n2, n3, n4};
      go_idle();
      build_exp(devid, nk, hang);
      devid_cfg = devid; nack_cfg = nk; hang_step = hang;
      log_q.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk(o_busy && o_ctrl[3:0] == 4'd0 && o_reg_addr == 8'h00 && o_step == 3'd0,
          {nm, "_load_latency"}, {o_busy, o_ctrl[3:0], o_reg_addr, o_step}, {1'b1, 4'd0, 8'h00, 3'd0});
      @(negedge clk);
      chk(o_ctrl[0] == 1'b1, {nm, "_req_enable"}, o_ctrl, 32'h1);
      while (o_busy && n < 6000) begin @(negedge clk); n++; end
      last_done_cyc = cyc;
      chk(!o_busy, {nm, "_completes"}, n, 32'd6000);
      chk(log_q.size() == exp_q.size(), {nm, "_txn_count"}, log_q.size(), exp_q.size());
      for (int i = 0; i < log_q.size() && i < exp_q.size(); i++)
         chk(log_q[i].addr == exp_q[i].addr && log_q[i].data == exp_q[i].data && log_q[i].op == exp_q[i].op,
             {nm, "_txn"}, {5'd0, log_q[i].op, log_q[i].addr, log_q[i].data, i[7:0]},
             {5'd0, exp_q[i].op, exp_q[i].addr, exp_q[i].data, i[7:0]});
      chk({o_err, o_err_code, o_step, o_running} == {exp_err, exp_code, exp_step, exp_run},
          {nm, "_outcome"}, {o_err, o_err_code, o_step, o_running}, {exp_err, exp_code, exp_step, exp_run});
      hang_step = NONE;
      hang_now = 1'b0;
   endtask

   initial begin
      int n;
      int nk [5];
      int gap, elapsed;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      repeat (3) @(negedge clk);
      chk(o_ctrl == 32'h62, "reset_ctrl", o_ctrl, 32'h62);
      chk({o_reg_addr, o_w_data, o_busy, o_running, o_err, o_err_code, o_step} == 23'd0,
          "reset_outputs", {o_reg_addr, o_w_data, o_busy, o_running, o_err, o_err_code, o_step}, 32'd0);
      rst = 1'b0;
      mon_en = 1'b1;

      // Pin the model against hand-derived expectations
      nk = '{0, 0, 0, 0, 0};
      build_exp(8'hAD, nk, NONE);
      chk(exp_q.size() == 5 && exp_q[1].addr == 8'h2F && exp_q[1].data == 8'h52 && exp_run == 1'b1,
          "model_nominal", exp_q.size(), 32'd5);
      nk = '{0, 0, 3, 0, 0};
      build_exp(8'hAD, nk, NONE);
      chk(exp_q.size() == 5 && exp_q[4].addr == 8'h2C && exp_code == 2'd2 && exp_step == 3'd2,
          "model_nack", {exp_q.size(), 2'(exp_code)}, {30'd5, 2'd2});

      // Nominal bring-up, reset settle gap, then stop with HW frame active
      run_scn("nominal", 8'hAD, 0, 0, 0, 0, NONE);
      gap = (log_q.size() >= 3) ? (log_q[2].t_start - log_q[1].t_end) : -1;
      chk(gap == R + 4, "rst_wait_gap", gap, R + 4);
      hw_active = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk); start = 1'b0; stop = 1'b0;
      chk(o_ctrl[3:1] == 3'd1 && !o_running && o_busy, "stop_opmode",
          {o_ctrl[3:1], o_running, o_busy}, {3'd1, 1'b0, 1'b1});
      repeat (5) @(negedge clk);
      chk(o_busy == 1'b1, "stop_waits_sm_enable", o_busy, 32'd1);
      hw_active = 1'b0;
      n = 0;
      while (o_busy && n < 50) begin @(negedge clk); n++; end
      chk(!o_busy && !o_running && !o_err && log_q.size() == 5, "stop_reaches_idle",
          {o_busy, o_running, o_err, 8'(log_q.size())}, {3'd0, 8'd5});

      run_scn("devid_bad", 8'h1D, 0, 0, 0, 0, NONE);
      run_scn("nack_step2", 8'hAD, 0, 3, 0, 0, NONE);
      run_scn("hang_step3", 8'hAD, 0, 0, 0, 0, 3);
      elapsed = last_done_cyc - log_q[$].t_start;
      chk(elapsed >= 2 * T && elapsed <= 2 * T + 6, "hang_timeout_window", elapsed, 2 * T + 2);
      chk(o_ctrl[0] == 1'b0, "hang_enable_low", o_ctrl, 32'h0);

      // Reset in the middle of the step3 frame, then rerun from step0
      go_idle();
      devid_cfg = 8'hAD; nack_cfg = '{0, 0, 0, 0, 0};
      log_q.delete();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 0;
      while (!(log_q.size() == 4 && ctl_phase == 2) && n < 3000) begin @(negedge clk); n++; end
      chk(log_q.size() == 4 && ctl_phase == 2, "reach_step3", log_q.size(), 32'd4);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      chk(o_ctrl == 32'h62, "midrun_reset_ctrl", o_ctrl, 32'h62);
      chk({o_reg_addr, o_w_data, o_busy, o_running, o_err, o_err_code, o_step} == 23'd0,
          "midrun_reset_outputs", {o_reg_addr, o_w_data, o_busy, o_running, o_err, o_err_code, o_step}, 32'd0);
      run_scn("rerun", 8'hAD, 0, 0, 0, 0, NONE);

      // Randomized DEVID / NACK patterns
      for (int k = 0; k < 8; k++) begin
         int r [5];
         logic [7:0] dv;
         dv = ($urandom_range(0, 3) == 0) ? 8'h1D : 8'hAD;
         for (int j = 1; j < 5; j++)
            r[j] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
         run_scn("random", dv, r[1], r[2], r[3], r[4], NONE);
      end

      go_idle();
      mon_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/adxl357_init_sequencer.md
# adxl357_init_sequencer

Sequencer that brings up the ADXL357 accelerometer through the I2C controller and then hands the controller over to hardware DRDY-driven streaming. It drives the controller's `i_ctrl`/`i_reg_addr`/`i_w_data` inputs and watches its `o_status` word. It verifies the device ID, runs a fixed register-write table, and recovers from NACK or hung transactions by retry or error. It sits between the CPU register file and the I2C controller instance.

## Interface
Parameters:
- CLK_RATE, 3'd6, I2C rate code placed in ctrl[6:4]
- TIMEOUT_CYC, 2_000_000, per-transaction i_clk budget (40 ms @ 50 MHz)
- RST_WAIT_CYC, 500_000, settle delay after soft-reset write (10 ms)
- MAX_RETRY, 2, retries per table step before error

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  system clock, 50 MHz
- i_rst  in  1  synchronous active-high reset
- i_start  in  1  one-cycle pulse; begins bring-up from IDLE or ERROR
- i_stop  in  1  one-cycle pulse; leaves RUN
- i_i2c_status  in  32  controller status; [1] finish, [10] sm_enable used
- i_rd_data  in  8  controller read result (ACCX[7:0])
- o_ctrl  out  32  controller control word: [0] enable, [3:1] op_mode, [6:4] CLK_RATE, rest 0
- o_reg_addr  out  8  register address for current step
- o_w_data  out  8  write data for current step
- o_busy  out  1  high in every state except IDLE, RUN, ERROR
- o_running  out  1  high in RUN
- o_err  out  1  sticky error, cleared by i_start
- o_err_code  out  2  0 none, 1 bad DEVID, 2 NACK after retries, 3 timeout after retries
- o_step  out  3  current table index

## Operation
- Reset values: o_ctrl = {25'b0, CLK_RATE, 3'd1, 1'b0} (CPU_WREG, disabled); o_reg_addr/o_w_data 0; o_busy/o_running/o_err 0; o_err_code 0; o_step 0.
- Table: step0 read 0x00 expect 0xAD; step1 write 0x2F←0x52 (reset) then RST_WAIT; step2 0x2C←0x81; step3 0x28←0x00; step4 0x2D←0x00. Step0 uses op_mode CPU_RREG(0), others CPU_WREG(1).
- States: IDLE → LOAD (drive addr/data/op_mode, clear finish_seen, load timer) → REQ (enable=1 until sm_enable=1) → WAIT_DONE (enable=0, finish_seen|=status[1], wait sm_enable=0) → CHECK → next LOAD / RST_WAIT / RUN / retry LOAD / ERROR.
- CHECK: write step with finish_seen=0 → NACK; read step compares i_rd_data to 0xAD, mismatch → ERROR code 1 without retry.
- Retry counter per step, reset in LOAD on step advance; exceeding MAX_RETRY → ERROR with code 2 or 3.
- Timer runs across REQ+WAIT_DONE; expiry → enable=0 and treat as timeout fail in CHECK, but only after sm_enable=0 is seen (return to IDLE path forced if still high after a second TIMEOUT_CYC: ERROR code 3).
- RUN: op_mode=4 (HW), enable=0. i_stop → STOPPING: op_mode back to 1, wait sm_enable=0, → IDLE.
- i_start ignored unless in IDLE or ERROR; i_stop ignored outside RUN; simultaneous i_start/i_stop in RUN: i_stop wins.
- i_rst mid-transaction: all outputs to reset values next edge; enable drop lets the controller finish its frame on its own.

## Timing
- i_i2c_status registered once before use; all decisions use the registered copy.
- i_start at edge N → LOAD at N+1, o_busy=1 and outputs valid at N+1; REQ at N+2.
- CHECK lasts exactly 1 cycle; RST_WAIT exactly RST_WAIT_CYC cycles.
- finish is a multi-cycle level (one i2c_clk period); no edge detect needed.
- o_err_code valid and stable whenever o_err=1.

## Structure
- adxl357_pkg: op-mode codes, register addresses (DEVID 0x00, RANGE 0x2C, FILTER 0x28, POWER_CTL 0x2D, RESET 0x2F), DEVID value 0xAD, init-table entry typedef and constant array, err-code enum, state enum.
- Single module; one shared down-counter serves timeout and RST_WAIT. No sub-module.

## Test plan
- Bench model ACKs all, DEVID 0xAD: i_start → five transactions in order with listed addr/data, RST_WAIT gap ≥ RST_WAIT_CYC, o_running=1, o_ctrl[3:1]=4.
- DEVID returns 0x1D → ERROR, o_err_code=1, no write issued.
- Step2 NACKs three times → three attempts of 0x2C, ERROR code 2, o_step=2.
- Model holds sm_enable high forever on step3 → ERROR code 3 after 2×TIMEOUT_CYC, enable=0.
- In RUN with HW transaction active, i_stop → o_ctrl op_mode=1 immediately, IDLE only after sm_enable=0.
- i_rst asserted during step3 WAIT_DONE → next cycle all outputs at reset values; later i_start reruns from step0.
